// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text terminal controller.
// Geometry is 70x30 cells of 9x16 pixels on a 640x480 raster.
package vga_text_pkg;
  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int CELL_W = 9;
  localparam int CELL_H = 16;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} term_state_t;
endpackage

// File: rtl/vga_row_map.sv
// Logical-to-physical row translation for the circular scroll buffer.
// The result is (i_row + i_top) mod ROWS, computed without a divider.
module vga_row_map
  import vga_text_pkg::*;
(
  input  logic [4:0] i_row,
  input  logic [4:0] i_top,
  output logic [4:0] o_row
);
  logic [5:0] w_sum;

  assign w_sum = {1'b0, i_row} + {1'b0, i_top};
  assign o_row = (w_sum >= 6'(ROWS)) ? 5'(w_sum - 6'(ROWS)) : w_sum[4:0];
endmodule

// File: rtl/vga_text_term_ctrl.sv
// Text terminal controller: byte stream in, character-buffer writes out,
// with cursor tracking, hardware scroll and cursor blink.
module vga_text_term_ctrl
  import vga_text_pkg::*;
#(
  parameter int BLINK_DIV = 12500000
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  output logic       wr_en,
  output logic [6:0] wr_x,
  output logic [4:0] wr_y,
  output logic [7:0] wr_data,
  input  logic [4:0] disp_y,
  output logic [4:0] rd_y,
  output logic [6:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       cursor_on,
  output logic       busy
);
  localparam int         BW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

  term_state_t   r_state;
  logic [6:0]    r_cur_x, r_clr_x, r_wr_x;
  logic [4:0]    r_cur_y, r_clr_y, r_top_row, r_wr_y;
  logic [7:0]    r_wr_data;
  logic [BW-1:0] r_blink;
  logic          r_ch_ready, r_wr_en, r_cursor_on, r_busy;
  logic [4:0]    w_wr_row;
  logic          w_accept, w_print, w_nl;

  vga_row_map u_wr_map (.i_row(r_cur_y), .i_top(r_top_row), .o_row(w_wr_row));
  vga_row_map u_rd_map (.i_row(disp_y),  .i_top(r_top_row), .o_row(rd_y));

  assign w_accept = ch_valid & r_ch_ready;
  assign w_print  = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
  assign w_nl     = w_accept & ((w_print & (r_cur_x == LAST_X)) | (ch_data == LF));

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_blink     <= '0;
      r_cursor_on <= 1'b0;
    end else if (r_blink == BW'(BLINK_DIV - 1)) begin
      r_blink     <= '0;
      r_cursor_on <= ~r_cursor_on;
    end else begin
      r_blink <= r_blink + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state    <= CLR_ALL;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_top_row  <= '0;
      r_clr_x    <= '0;
      r_clr_y    <= '0;
      r_ch_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_data  <= SPACE;
      r_busy     <= 1'b1;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        CLR_ALL, CLR_ROW: begin
          r_wr_en   <= 1'b1;
          r_wr_x    <= r_clr_x;
          r_wr_y    <= r_clr_y;
          r_wr_data <= SPACE;
          if (r_clr_x == LAST_X) begin
            r_clr_x <= '0;
            // A row clear ends after one row; a full clear after the last row.
            if (r_state == CLR_ROW || r_clr_y == LAST_Y) begin
              r_state    <= IDLE;
              r_ch_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_clr_y <= r_clr_y + 1'b1;
            end
          end else begin
            r_clr_x <= r_clr_x + 1'b1;
          end
        end
        IDLE: begin
          if (w_accept) begin
            if (w_print) begin
              r_wr_en   <= 1'b1;
              r_wr_x    <= r_cur_x;
              r_wr_y    <= w_wr_row;
              r_wr_data <= ch_data;
              if (r_cur_x != LAST_X) r_cur_x <= r_cur_x + 1'b1;
            end else if (ch_data == CR) begin
              r_cur_x <= '0;
            end else if (ch_data == BS && r_cur_x != '0) begin
              r_cur_x   <= r_cur_x - 1'b1;
              r_wr_en   <= 1'b1;
              r_wr_x    <= r_cur_x - 1'b1;
              r_wr_y    <= w_wr_row;
              r_wr_data <= SPACE;
            end
          end
          if (w_nl) begin
            r_cur_x <= '0;
            if (r_cur_y != LAST_Y) begin
              r_cur_y <= r_cur_y + 1'b1;
            end else begin
              // Scroll: the old top row becomes the new bottom row and is blanked.
              r_top_row  <= (r_top_row == LAST_Y) ? '0 : r_top_row + 1'b1;
              r_clr_x    <= '0;
              r_clr_y    <= r_top_row;
              r_state    <= CLR_ROW;
              r_ch_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        default: r_state <= CLR_ALL;
      endcase
    end
  end

  assign ch_ready  = r_ch_ready;
  assign wr_en     = r_wr_en;
  assign wr_x      = r_wr_x;
  assign wr_y      = r_wr_y;
  assign wr_data   = r_wr_data;
  assign cursor_x  = r_cur_x;
  assign cursor_y  = r_cur_y;
  assign cursor_on = r_cursor_on;
  assign busy      = r_busy;
endmodule

// File: tb/tb_vga_text_term_ctrl.sv
// Scoreboard bench for vga_text_term_ctrl: expected buffer writes are queued
// by the stimulus and checked by a monitor whenever wr_en is seen.
module tb_vga_text_term_ctrl;
  logic       pclk = 1'b0;
  logic       reset, ch_valid, ch_ready, wr_en, cursor_on, busy;
  logic [7:0] ch_data, wr_data;
  logic [6:0] wr_x, cursor_x;
  logic [4:0] wr_y, disp_y, rd_y, cursor_y;

  typedef struct packed {
    logic [6:0] x;
    logic [4:0] y;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  n_wr   = 0;

  vga_text_term_ctrl #(.BLINK_DIV(4)) dut (
    .pclk(pclk), .reset(reset),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .disp_y(disp_y), .rd_y(rd_y),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .cursor_on(cursor_on), .busy(busy)
  );

  always #5 pclk = ~pclk;

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge pclk) begin
    if (wr_en === 1'b1) begin
      n_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got x=%0d y=%0d d=%h want no write", wr_x, wr_y, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wr_x, wr_y, wr_data} !== mon_e) begin
          errors++;
          $display("FAIL write got x=%0d y=%0d d=%h want x=%0d y=%0d d=%h",
                   wr_x, wr_y, wr_data, mon_e.x, mon_e.y, mon_e.d);
        end
      end
    end
  end

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input logic [7:0] d);
    exp_q.push_back('{x: 7'(x), y: 5'(y), d: d});
  endtask

  task automatic push_clear_all();
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 70; x++) push(x, y, 8'h20);
  endtask

  task automatic wait_ready(input int max_cyc);
    int n;
    n = 0;
    while (ch_ready !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    if (ch_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got ch_ready=%b want 1 within %0d cycles", ch_ready, max_cyc);
    end
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready(3000);
    ch_valid = 1'b1;
    ch_data  = b;
    step();
    ch_valid = 1'b0;
  endtask

  task automatic drain_check(input string name);
    step();
    step();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    int n, last, toggles;
    logic prev;
    reset = 1'b1; ch_valid = 1'b1; ch_data = 8'h07; disp_y = 5'd0;
    step();
    step();
    chk("rst_busy", busy, 1);
    chk("rst_ready", ch_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 8'h20);
    chk("rst_wr_xy", {wr_x, wr_y}, 0);
    chk("rst_cursor", {cursor_x, cursor_y}, 0);
    chk("rst_cursor_on", cursor_on, 0);

    // Full clear with ch_valid held high carrying an ignored code.
    push_clear_all();
    reset = 1'b0;
    wait_ready(3000);
    chk("clr_all_writes", n_wr, 2100);
    chk("clr_all_busy", busy, 0);
    chk("clr_all_q", exp_q.size(), 0);
    step();
    ch_valid = 1'b0;
    chk("bell_cursor", {cursor_x, cursor_y}, 0);

    // Print two bytes back-to-back.
    push(0, 0, 8'h48); send(8'h48);
    push(1, 0, 8'h69); send(8'h69);
    chk("print_cx", cursor_x, 2);
    chk("print_cy", cursor_y, 0);
    drain_check("print_q");

    // Line wrap after 70 printable bytes.
    send(8'h0D);
    for (int i = 0; i < 70; i++) begin
      push(i, 0, 8'h41 + 8'(i % 26));
      send(8'h41 + 8'(i % 26));
    end
    chk("wrap_cx", cursor_x, 0);
    chk("wrap_cy", cursor_y, 1);
    drain_check("wrap_q");

    // Control codes at row 3.
    send(8'h0A); send(8'h0A);
    for (int i = 0; i < 5; i++) begin push(i, 3, 8'h61 + 8'(i)); send(8'h61 + 8'(i)); end
    chk("pre_cr_cx", cursor_x, 5);
    send(8'h0D);
    chk("cr_cx", cursor_x, 0);
    chk("cr_cy", cursor_y, 3);
    for (int i = 0; i < 5; i++) begin push(i, 3, 8'h61 + 8'(i)); send(8'h61 + 8'(i)); end
    push(4, 3, 8'h20); send(8'h08);
    chk("bs_cx", cursor_x, 4);
    chk("bs_cy", cursor_y, 3);
    send(8'h0D);
    send(8'h08);
    chk("bs0_cx", cursor_x, 0);
    send(8'h07);
    chk("bell_cxy", {cursor_x, cursor_y}, {7'd0, 5'd3});
    drain_check("ctrl_q");

    // Scroll from (10,29) with top_row=0.
    for (int i = 0; i < 26; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) begin push(i, 29, 8'h30 + 8'(i)); send(8'h30 + 8'(i)); end
    chk("pre_scroll_cxy", {cursor_x, cursor_y}, {7'd10, 5'd29});
    for (int i = 0; i < 70; i++) push(i, 0, 8'h20);
    send(8'h0A);
    n = 0;
    while (ch_ready !== 1'b1 && n < 200) begin n++; step(); end
    chk("scroll_ready_low", n, 70);
    chk("scroll_cxy", {cursor_x, cursor_y}, {7'd0, 5'd29});
    disp_y = 5'd29; #1;
    chk("rd_y_29", rd_y, 0);
    disp_y = 5'd0; #1;
    chk("rd_y_0", rd_y, 1);
    push(0, 0, 8'h5A); send(8'h5A);
    drain_check("scroll_q");

    // Second scroll clears physical row 1; reset lands during column 30.
    for (int i = 0; i < 70; i++) push(i, 1, 8'h20);
    send(8'h0A);
    n = 0;
    while (!(wr_en === 1'b1 && wr_x == 7'd30) && n < 200) begin n++; step(); end
    chk("midscroll_reach_col30", wr_x, 30);
    reset = 1'b1;
    step();
    exp_q.delete();
    chk("midrst_busy", busy, 1);
    chk("midrst_ready", ch_ready, 0);
    chk("midrst_cursor", {cursor_x, cursor_y}, 0);
    disp_y = 5'd5; #1;
    chk("midrst_rd_y", rd_y, 5);
    push_clear_all();
    reset = 1'b0;
    n = n_wr;
    wait_ready(3000);
    chk("reclr_writes", n_wr - n, 2100);
    push(0, 0, 8'h51); send(8'h51);
    drain_check("reclr_q");

    // Blink period of 4 cycles.
    prev = cursor_on; last = -1; toggles = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cursor_on !== prev) begin
        toggles++;
        if (last >= 0) chk("blink_period", i - last, 4);
        last = i;
        prev = cursor_on;
      end
    end
    chk("blink_toggles", toggles, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_text_term_ctrl.md
Name: vga_text_term_ctrl

Overview:
- Terminal controller for the 640x480 text-mode VGA path.
- Accepts an ASCII byte stream over a valid/ready handshake and maintains the cursor position.
- Drives the write port of the dual-port character buffer. Buffer geometry: 70 columns x 30 rows, 9x16 glyph cells.
- Implements hardware scrolling through a circular top-row offset, and translates the display's logical row (y from the VGA timing block) to the physical buffer row on the read side.

Parameters:
- COLS, 70: character columns per row (7-bit column index).
- ROWS, 30: character rows (5-bit row index).
- BLINK_DIV, 12500000: pclk cycles per cursor blink half-period (0.5 s at 25 MHz).

Ports:
- pclk  in  1  25 MHz pixel clock, sole clock.
- reset  in  1  synchronous, active-high reset.
- ch_valid  in  1  input byte valid.
- ch_data  in  8  ASCII byte.
- ch_ready  out  1  controller can accept a byte this cycle.
- wr_en  out  1  character buffer write strobe.
- wr_x  out  7  buffer column for the write.
- wr_y  out  5  physical buffer row for the write.
- wr_data  out  8  ASCII code to write.
- disp_y  in  5  logical row currently scanned by the VGA timing block.
- rd_y  out  5  physical row for the display read port (combinational).
- cursor_x  out  7  cursor column (logical).
- cursor_y  out  5  cursor row (logical).
- cursor_on  out  1  blink phase; display inverts the cell at the cursor when high.
- busy  out  1  a clear sequence is in progress.

Behaviour:
- **One clock, one reset.** Single clock pclk. Reset is synchronous and active-high, port name reset; it is sampled only on the pclk rising edge.
- **Reset values.** State CLR_ALL; cur_x=0, cur_y=0, top_row=0, clr_x=0, clr_y=0, blink counter=0; cursor_on=0, ch_ready=0, wr_en=0, wr_x=0, wr_y=0, wr_data=0x20, busy=1.
- **Reset mid-operation.** Reset asserted during any state (including a scroll) restarts CLR_ALL from (0,0). No pending write survives.
- **FSM states:** CLR_ALL, IDLE, CLR_ROW.
- **CLR_ALL.**
  - Issues one write per cycle of 0x20 at (clr_x, clr_y), raster order, columns 0..COLS-1 within rows 0..ROWS-1: exactly COLS*ROWS = 2100 writes.
  - After the write at (69,29), the next state is IDLE and busy=0.
  - ch_ready=0 throughout.
- **IDLE.**
  - ch_ready=1. A byte is accepted in any cycle where ch_valid & ch_ready.
  - Write outputs are registered: wr_en pulses in the cycle after acceptance.
  - Back-to-back acceptance gives 1 byte/cycle throughout.
- **Byte decode on accept:**
  - 0x20..0x7E (printable): write ch_data at (cur_x, phys(cur_y)). If cur_x == COLS-1, perform a newline; otherwise cur_x+1.
  - 0x0A (LF): newline. No write.
  - 0x0D (CR): cur_x=0. No write.
  - 0x08 (BS): if cur_x>0, cur_x-1 and write 0x20 at the new position. At cur_x=0, no action (no reverse wrap).
  - All other codes: discarded. No state change.
- **Newline.**
  - cur_x=0.
  - If cur_y < ROWS-1: cur_y+1.
  - Else (scroll): cur_y stays ROWS-1, top_row advances mod ROWS, and the FSM enters CLR_ROW for physical row = old top_row.
- **CLR_ROW.**
  - ch_ready=0, busy=1.
  - COLS consecutive writes of 0x20 to columns 0..69 of the target row, then IDLE.
  - The printable character that triggered the wrap has already been written (in the acceptance's write cycle) before clearing begins.
- **Row mapping.** phys(r) = r + top_row; subtract ROWS if the sum >= ROWS. Width 6 bits internally, result 5 bits. rd_y = phys(disp_y), combinational, zero latency.
- **Blink.** The counter runs in all states. At BLINK_DIV-1 it wraps to 0 and toggles cursor_on.
- **Outputs.** cursor_x/cursor_y are cur_x/cur_y, registered.
- **Write collisions.** wr_en is never asserted for two targets in one cycle. Collisions with display reads are resolved by the dual-port buffer; the display may read the old glyph for one frame.

Decomposition:
- Shared package vga_text_pkg holds:
  - COLS=70, ROWS=30, CELL_W=9, CELL_H=16.
  - ASCII constants SPACE=0x20, LF=0x0A, CR=0x0D, BS=0x08.
  - The term_state_t enum.
- One sub-module, vga_row_map: combinational modular add (logical row + top_row mod ROWS). Instantiated twice, once for the write row and once for rd_y.

Test Plan:
- **Reset clear:** reset 1 cycle, then hold ch_valid=1 -> exactly 2100 wr_en pulses, wr_data=0x20, last at (69,29); ch_ready rises only in the following cycle; busy 1->0 at the same point.
- **Print:** send 'H','i' back-to-back from IDLE -> writes (0,0)=0x48 then (1,0)=0x69 on consecutive cycles; cursor_x=2, cursor_y=0.
- **Line wrap:** 70 printable bytes -> 70th written at (69,0); cursor then at (0,1); no extra write.
- **Control codes:**
  - CR at cursor (5,3) -> cursor (0,3), no write.
  - BS at (5,3) -> 0x20 written at (4,3), cursor (4,3).
  - BS at (0,3) -> no write, no move.
  - 0x07 -> ignored.
- **Scroll:** with cursor at (10,29) and top_row=0, send LF -> ch_ready low for exactly 70 cycles; writes of 0x20 to physical row 0, columns 0..69; top_row=1; with disp_y=29, rd_y=0; with disp_y=0, rd_y=1; cursor (0,29).
- **Reset mid-scroll and blink:**
  - Assert reset during CLR_ROW at column 30 -> CLR_ALL restarts at (0,0), top_row=0.
  - With BLINK_DIV=4 -> cursor_on toggles every 4 cycles.
